pipe_stage_reg: RTL and testbench

- Parametrised, flow-controlled pipeline stage register that succeeds the fixed-width, always-advancing inter-stage latches (ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle between stages using a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput with registered backpressure.
- Supports flush (bubble insertion) for branch/hazard handling, plus a saturating stall counter for performance debug.

---
 rtl/pipe_stage_reg_pkg.sv | 23 ++
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg_stall_counter.sv | 20 ++
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for flow-controlled pipeline stage registers:
// bundle widths, control-bit positions and the stage occupancy encoding.
package pipe_stage_reg_pkg;

  // Bundle widths of the EX/MEM boundary
  localparam int EX_MEM_CTRL_W = 5;
  localparam int EX_MEM_DATA_W = 128;

  // Bit positions inside the control bundle
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEM2REG  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ZERO     = 4;

  // Occupancy of a skid-buffered stage: main holds the older entry, skid the newer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// master = the side that feeds Valid_In/Ready_In, slave = the stage register.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 128
);
  logic              Valid_In;
  logic              Ready_Out;
  logic [CTRL_W-1:0] Ctrl_In;
  logic [DATA_W-1:0] Data_In;
  logic              Valid_Out;
  logic              Ready_In;
  logic [CTRL_W-1:0] Ctrl_Out;
  logic [DATA_W-1:0] Data_Out;

  modport master (
    output Valid_In, Ctrl_In, Data_In, Ready_In,
    input  Ready_Out, Valid_Out, Ctrl_Out, Data_Out
  );

  modport slave (
    input  Valid_In, Ctrl_In, Data_In, Ready_In,
    output Ready_Out, Valid_Out, Ctrl_Out, Data_Out
  );
endinterface

// File: rtl/pipe_stage_reg_stall_counter.sv
// Saturating counter of downstream-stall cycles; cleared only by reset.
module pipe_stage_reg_stall_counter #(
  parameter int STALL_W = 16
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               inc,
  output logic [STALL_W-1:0] count
);
  localparam logic [STALL_W-1:0] CNT_MAX = {STALL_W{1'b1}};

  // Count stall cycles, sticking at the all-ones value
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= {STALL_W{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + STALL_W'(1);
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register carrying a control and a data
// bundle. SKID=1 adds a second entry so Ready_Out can come from a flop
// without losing throughput; SKID=0 is a single entry with combinational
// Ready_Out. Flush empties the stage; Ctrl_Out is zero whenever no entry is
// valid so write enables are inert in bubbles.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W  = EX_MEM_CTRL_W,
  parameter int DATA_W  = EX_MEM_DATA_W,
  parameter int SKID    = 1,
  parameter int STALL_W = 16
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               Flush_In,
  pipe_stage_reg_if.slave    bus,
  output logic [STALL_W-1:0] StallCnt_Out
);

  logic              valid_r;
  logic              ready_s;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              stall_s;

  assign in_fire_s  = bus.Valid_In & ready_s;
  assign out_fire_s = valid_r & bus.Ready_In;
  assign stall_s    = valid_r & ~bus.Ready_In;

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e      state_r;
      logic              ready_r;
      logic [CTRL_W-1:0] skid_ctrl_r;
      logic [DATA_W-1:0] skid_data_r;

      assign ready_s = ready_r;

      // Two-entry occupancy FSM; main always holds the older entry
      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
          state_r     <= ST_EMPTY;
          valid_r     <= 1'b0;
          ready_r     <= 1'b1;
          main_ctrl_r <= {CTRL_W{1'b0}};
          main_data_r <= {DATA_W{1'b0}};
          skid_ctrl_r <= {CTRL_W{1'b0}};
          skid_data_r <= {DATA_W{1'b0}};
        end else if (Flush_In) begin
          // flush beats both transfers; any offered entry is dropped
          state_r     <= ST_EMPTY;
          valid_r     <= 1'b0;
          ready_r     <= 1'b1;
          main_ctrl_r <= {CTRL_W{1'b0}};
        end else begin
          case (state_r)
            ST_EMPTY: begin
              if (in_fire_s) begin
                state_r     <= ST_FULL;
                valid_r     <= 1'b1;
                main_ctrl_r <= bus.Ctrl_In;
                main_data_r <= bus.Data_In;
              end
            end
            ST_FULL: begin
              if (in_fire_s && out_fire_s) begin
                main_ctrl_r <= bus.Ctrl_In;
                main_data_r <= bus.Data_In;
              end else if (out_fire_s) begin
                state_r     <= ST_EMPTY;
                valid_r     <= 1'b0;
                main_ctrl_r <= {CTRL_W{1'b0}};
              end else if (in_fire_s) begin
                state_r     <= ST_SKID;
                ready_r     <= 1'b0;
                skid_ctrl_r <= bus.Ctrl_In;
                skid_data_r <= bus.Data_In;
              end
            end
            ST_SKID: begin
              if (out_fire_s) begin
                state_r     <= ST_FULL;
                ready_r     <= 1'b1;
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
              end
            end
            default: begin
              state_r     <= ST_EMPTY;
              valid_r     <= 1'b0;
              ready_r     <= 1'b1;
              main_ctrl_r <= {CTRL_W{1'b0}};
            end
          endcase
        end
      end
    end else begin : g_single
      assign ready_s = ~valid_r | bus.Ready_In;

      // Single entry: load on accept, empty on departure without refill
      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
          valid_r     <= 1'b0;
          main_ctrl_r <= {CTRL_W{1'b0}};
          main_data_r <= {DATA_W{1'b0}};
        end else if (Flush_In) begin
          valid_r     <= 1'b0;
          main_ctrl_r <= {CTRL_W{1'b0}};
        end else if (in_fire_s) begin
          valid_r     <= 1'b1;
          main_ctrl_r <= bus.Ctrl_In;
          main_data_r <= bus.Data_In;
        end else if (out_fire_s) begin
          valid_r     <= 1'b0;
          main_ctrl_r <= {CTRL_W{1'b0}};
        end
      end
    end
  endgenerate

  assign bus.Ready_Out = ready_s;
  assign bus.Valid_Out = valid_r;
  assign bus.Ctrl_Out  = main_ctrl_r;
  assign bus.Data_Out  = main_data_r;

  pipe_stage_reg_stall_counter #(
    .STALL_W (STALL_W)
  ) u_stall_counter (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .inc     (stall_s),
    .count   (StallCnt_Out)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (SKID=1, 16-bit counter) and a
// single-entry instance (SKID=0, 2-bit counter) run side by side against a
// queue-based reference model of the accepted-entry stream.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;

  // stimulus for instance 0 (skid) and instance 1 (single entry)
  logic         f0, v0, r0, f1, v1, r1;
  logic [4:0]   c0, c1;
  logic [127:0] d0, d1;
  logic [15:0]  s0;
  logic [1:0]   s1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: queue of {ctrl,data} entries in acceptance order
  logic [132:0] q0[$];
  logic [132:0] q1[$];
  int cnt0, cnt1;
  bit acc0, acc1;

  pipe_stage_reg_if #(.CTRL_W(5), .DATA_W(128)) if0 ();
  pipe_stage_reg_if #(.CTRL_W(5), .DATA_W(128)) if1 ();

  assign if0.Valid_In = v0;
  assign if0.Ready_In = r0;
  assign if0.Ctrl_In  = c0;
  assign if0.Data_In  = d0;
  assign if1.Valid_In = v1;
  assign if1.Ready_In = r1;
  assign if1.Ctrl_In  = c1;
  assign if1.Data_In  = d1;

  pipe_stage_reg #(.CTRL_W(5), .DATA_W(128), .SKID(1), .STALL_W(16)) u_dut0 (
    .CLOCK(clk), .RESET_N(rst_n), .Flush_In(f0), .bus(if0), .StallCnt_Out(s0)
  );

  pipe_stage_reg #(.CTRL_W(5), .DATA_W(128), .SKID(0), .STALL_W(2)) u_dut1 (
    .CLOCK(clk), .RESET_N(rst_n), .Flush_In(f1), .bus(if1), .StallCnt_Out(s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // compare both instances against what the model currently holds
  task automatic check_all(input string ph);
    logic [132:0] h;
    h = (q0.size() > 0) ? q0[0] : 133'd0;
    chk({ph, ".valid0"}, 128'(if0.Valid_Out), 128'(q0.size() > 0));
    chk({ph, ".ctrl0"},  128'(if0.Ctrl_Out),  128'(h[132:128]));
    if (q0.size() > 0) chk({ph, ".data0"}, if0.Data_Out, h[127:0]);
    chk({ph, ".ready0"}, 128'(if0.Ready_Out), 128'(q0.size() < 2));
    chk({ph, ".stall0"}, 128'(s0), 128'(cnt0));
    h = (q1.size() > 0) ? q1[0] : 133'd0;
    chk({ph, ".valid1"}, 128'(if1.Valid_Out), 128'(q1.size() > 0));
    chk({ph, ".ctrl1"},  128'(if1.Ctrl_Out),  128'(h[132:128]));
    if (q1.size() > 0) chk({ph, ".data1"}, if1.Data_Out, h[127:0]);
    chk({ph, ".ready1"}, 128'(if1.Ready_Out), 128'((q1.size() == 0) || r1));
    chk({ph, ".stall1"}, 128'(s1), 128'(cnt1));
  endtask

  // advance the model by one clock edge using the inputs presented now
  task automatic model_step();
    bit rd, o, i;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst_n == 1'b0) begin
      q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
    end else begin
      rd = (q0.size() < 2); o = (q0.size() > 0) && r0; i = v0 && rd;
      if ((q0.size() > 0) && !r0 && (cnt0 < 65535)) cnt0++;
      if (f0) q0.delete();
      else begin
        if (o) void'(q0.pop_front());
        if (i) begin q0.push_back({c0, d0}); acc0 = 1'b1; end
      end
      rd = (q1.size() == 0) || r1; o = (q1.size() > 0) && r1; i = v1 && rd;
      if ((q1.size() > 0) && !r1 && (cnt1 < 3)) cnt1++;
      if (f1) q1.delete();
      else begin
        if (o) void'(q1.pop_front());
        if (i) begin q1.push_back({c1, d1}); acc1 = 1'b1; end
      end
    end
  endtask

  // inputs are set at a falling edge; check, step model, move to next falling edge
  task automatic cycle(input string ph);
    #1;
    check_all(ph);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit done;
    logic [127:0] nxt;
    rst_n = 1'b0;
    f0 = 1'b0; v0 = 1'b0; r0 = 1'b1; c0 = 5'd0; d0 = 128'd0;
    f1 = 1'b0; v1 = 1'b0; r1 = 1'b1; c1 = 5'd0; d1 = 128'd0;
    q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
    @(negedge clk);

    // reset state
    cycle("rst");
    chk("rst.data0", if0.Data_Out, 128'd0);
    chk("rst.data1", if1.Data_Out, 128'd0);
    cycle("rst");
    rst_n = 1'b1;

    // steady flow, one entry per cycle, no gaps
    r0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v0 = 1'b1; d0 = 128'(i); c0 = 5'($urandom_range(0, 31));
      cycle("flow");
      if (i == 1) chk("flow.first", if0.Data_Out, 128'd1);
    end
    v0 = 1'b0;
    for (int i = 0; i < 3; i++) cycle("flow.drain");
    chk("flow.stall", 128'(s0), 128'd0);

    // backpressure: A in main, B in skid, C refused
    r0 = 1'b0; v0 = 1'b1;
    d0 = 128'hA; c0 = 5'd1; cycle("bp");
    d0 = 128'hB; c0 = 5'd2; cycle("bp");
    chk("bp.ready_low", 128'(if0.Ready_Out), 128'd0);
    d0 = 128'hC; c0 = 5'd3; cycle("bp");
    cycle("bp");
    chk("bp.hold_a", if0.Data_Out, 128'hA);
    chk("bp.stall3", 128'(s0), 128'd3);
    r0 = 1'b1; done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      cycle("bp.rel");
      if (acc0) done = 1'b1;
    end
    chk("bp.c_accepted", 128'(done), 128'd1);
    v0 = 1'b0;
    for (int i = 0; i < 4; i++) cycle("bp.drain");

    // flush while both entries are held, with an input offered
    r0 = 1'b0; v0 = 1'b1;
    d0 = 128'h10; c0 = 5'h1f; cycle("fl");
    d0 = 128'h11; cycle("fl");
    f0 = 1'b1; d0 = 128'h12; cycle("fl");
    f0 = 1'b0; v0 = 1'b0; r0 = 1'b1;
    chk("fl.valid", 128'(if0.Valid_Out), 128'd0);
    chk("fl.ctrl", 128'(if0.Ctrl_Out), 128'd0);
    chk("fl.ready", 128'(if0.Ready_Out), 128'd1);
    for (int i = 0; i < 3; i++) cycle("fl.after");

    // control masking in bubbles
    c0 = 5'h1f; d0 = 128'h55; v0 = 1'b0;
    for (int i = 0; i < 3; i++) cycle("bub");
    v0 = 1'b1; cycle("bub");
    v0 = 1'b0;
    chk("bub.ctrl_on", 128'(if0.Ctrl_Out), 128'h1f);
    for (int i = 0; i < 3; i++) cycle("bub.drain");

    // single-entry mode with toggling downstream ready
    nxt = 128'h100;
    v1 = 1'b1; d1 = nxt; c1 = 5'($urandom_range(0, 31));
    for (int i = 0; i < 12; i++) begin
      r1 = (i % 2 == 0);
      cycle("s0");
      if (acc1) begin
        nxt = nxt + 128'd1; d1 = nxt; c1 = 5'($urandom_range(0, 31));
      end
    end
    v1 = 1'b0; r1 = 1'b1;
    for (int i = 0; i < 3; i++) cycle("s0.drain");

    // async reset pulse while both stages hold a stalled entry
    r0 = 1'b0; r1 = 1'b0; v0 = 1'b1; v1 = 1'b1;
    d0 = 128'h77; d1 = 128'h88; c0 = 5'h1f; c1 = 5'h1f;
    cycle("ar");
    v0 = 1'b0; v1 = 1'b0;
    cycle("ar");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid0", 128'(if0.Valid_Out), 128'd0);
    chk("ar.ctrl0", 128'(if0.Ctrl_Out), 128'd0);
    chk("ar.data0", if0.Data_Out, 128'd0);
    chk("ar.stall0", 128'(s0), 128'd0);
    chk("ar.ready0", 128'(if0.Ready_Out), 128'd1);
    chk("ar.valid1", 128'(if1.Valid_Out), 128'd0);
    chk("ar.ctrl1", 128'(if1.Ctrl_Out), 128'd0);
    chk("ar.stall1", 128'(s1), 128'd0);
    q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // stall counter saturation on the 2-bit instance
    v1 = 1'b1; d1 = 128'h99; c1 = 5'h3; r1 = 1'b0;
    cycle("sat");
    v1 = 1'b0;
    for (int i = 0; i < 5; i++) cycle("sat");
    chk("sat.value", 128'(s1), 128'd3);
    r1 = 1'b1;
    for (int i = 0; i < 2; i++) cycle("sat.drain");

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 3) != 0); r0 = ($urandom_range(0, 3) != 0);
      f0 = ($urandom_range(0, 15) == 0);
      c0 = 5'($urandom_range(0, 31)); d0 = rnd128();
      v1 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 2) != 0);
      f1 = ($urandom_range(0, 15) == 0);
      c1 = 5'($urandom_range(0, 31)); d1 = rnd128();
      cycle("rnd");
    end
    f0 = 1'b0; f1 = 1'b0; v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
    for (int i = 0; i < 4; i++) cycle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
